// File: rtl/mux_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mux_scan_ctrl
// Purpose  : Round-robin scan controller for a 4:1 bit multiplexer stage.
//            Walks the mux select across the enabled channels in ascending
//            order. Each channel is held for dwell+1 cycles, and the mux
//            output is sampled on the last cycle of that dwell. The
//            collected bits are then offered as a 4-bit snapshot on a
//            valid/ready handshake.
// Ports    : clk        - system clock, rising edge
//            rst        - asynchronous active-high reset
//            start      - scan request, sampled only while idle
//            mask[3:0]  - channel enables, latched on accepted start
//            dwell      - per-channel dwell count, latched on accepted start
//            mux_sel    - registered mux select
//            mux_out    - mux output (combinational from mux_sel)
//            snap_data  - captured bits, bit i is channel i
//            snap_valid - snapshot available
//            snap_ready - consumer accepts snapshot
//            busy       - controller not idle
// Revision : 1.0 - initial release
// ============================================================================
module mux_scan_ctrl #(
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [3:0]         mask,
    input  logic [DWELL_W-1:0] dwell,
    output logic [1:0]         mux_sel,
    input  logic               mux_out,
    output logic [3:0]         snap_data,
    output logic               snap_valid,
    input  logic               snap_ready,
    output logic               busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam logic [DWELL_W-1:0] C_CNT_ONE = {{(DWELL_W-1){1'b0}}, 1'b1};

    logic [1:0]         r_state;
    logic [3:0]         r_mask;
    logic [DWELL_W-1:0] r_dwell;
    logic [DWELL_W-1:0] r_cnt;
    logic [1:0]         r_mux_sel;
    logic [3:0]         r_snap_data;
    logic               r_snap_valid;

    logic [1:0]         w_first_sel;
    logic [1:0]         w_next_sel;
    logic               w_next_vld;
    logic               w_last_dwell;

    // Lowest set bit of the incoming mask: descending loop, so the lowest
    // index is written last and wins.
    always_comb begin
        w_first_sel = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (mask[i]) begin
                w_first_sel = 2'(i);
            end
        end
    end

    // Lowest latched mask bit strictly above the current channel. No
    // wrap-around: if nothing is above, the scan is complete.
    always_comb begin
        w_next_vld = 1'b0;
        w_next_sel = r_mux_sel;
        for (int i = 3; i >= 0; i--) begin
            if (r_mask[i] && (i > int'(r_mux_sel))) begin
                w_next_vld = 1'b1;
                w_next_sel = 2'(i);
            end
        end
    end

    // Compared before incrementing, so an all-ones dwell never overflows.
    assign w_last_dwell = (r_cnt == r_dwell);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_mask       <= 4'd0;
            r_dwell      <= {DWELL_W{1'b0}};
            r_cnt        <= {DWELL_W{1'b0}};
            r_mux_sel    <= 2'd0;
            r_snap_data  <= 4'd0;
            r_snap_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_snap_data <= 4'd0;
                        if (mask != 4'd0) begin
                            r_mask    <= mask;
                            r_dwell   <= dwell;
                            r_mux_sel <= w_first_sel;
                            r_cnt     <= {DWELL_W{1'b0}};
                            r_state   <= ST_SCAN;
                        end else begin
                            // Empty scan: present an all-zero snapshot at once.
                            r_snap_valid <= 1'b1;
                            r_state      <= ST_HOLD;
                        end
                    end
                end

                ST_SCAN: begin
                    if (w_last_dwell) begin
                        r_snap_data[r_mux_sel] <= mux_out;
                        r_cnt                  <= {DWELL_W{1'b0}};
                        if (w_next_vld) begin
                            r_mux_sel <= w_next_sel;
                        end else begin
                            // Last channel: select stays put through HOLD.
                            r_snap_valid <= 1'b1;
                            r_state      <= ST_HOLD;
                        end
                    end else begin
                        r_cnt <= r_cnt + C_CNT_ONE;
                    end
                end

                ST_HOLD: begin
                    if (snap_ready) begin
                        r_snap_valid <= 1'b0;
                        r_mux_sel    <= 2'd0;
                        r_state      <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign mux_sel    = r_mux_sel;
    assign snap_data  = r_snap_data;
    assign snap_valid = r_snap_valid;
    assign busy       = (r_state != ST_IDLE);

endmodule
`default_nettype wire
